// File: rtl/inverse_factorial.sv
// Iterative inverse factorial: finds the largest n with n! <= value, one candidate per clock.
// Optional err output (value == 0) is enabled by defining INVERSE_FACTORIAL_ERR_EN.
`timescale 1ns/1ps
module inverse_factorial #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned NW    = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    n,
    output logic             exact
`ifdef INVERSE_FACTORIAL_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] prod, prod_d;
    logic [NW-1:0]    k, k_d;
    logic [NW-1:0]    n_q, n_d;
    logic             exact_q, exact_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zpend, zpend_d;
`ifdef INVERSE_FACTORIAL_ERR_EN
    logic             err_q, err_d;
`endif
    logic [2*WIDTH-1:0] t;

    // Full-width product so the overflow past v_q is never masked by truncation.
    assign t = (2*WIDTH)'(prod) * (2*WIDTH)'(k);

    always_comb begin
        state_d = state;
        v_d     = v_q;
        prod_d  = prod;
        k_d     = k;
        n_d     = n_q;
        exact_d = exact_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zpend_d = 1'b0;
`ifdef INVERSE_FACTORIAL_ERR_EN
        err_d   = err_q;
`endif
        case (state)
            IDLE: begin
                // A zero operand completes one edge after acceptance without leaving IDLE,
                // so a new start can be accepted on the same edge the zero result lands.
                if (zpend) begin
                    done_d  = 1'b1;
                    n_d     = '0;
                    exact_d = 1'b0;
`ifdef INVERSE_FACTORIAL_ERR_EN
                    err_d   = 1'b1;
`endif
                end
                if (start) begin
                    if (value != '0) begin
                        v_d     = value;
                        prod_d  = WIDTH'(1);
                        k_d     = NW'(1);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        zpend_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (t <= (2*WIDTH)'(v_q)) begin
                    prod_d = t[WIDTH-1:0];
                    k_d    = k + NW'(1);
                end else begin
                    n_d     = k - NW'(1);
                    exact_d = (prod == v_q);
`ifdef INVERSE_FACTORIAL_ERR_EN
                    err_d   = 1'b0;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            v_q     <= '0;
            prod    <= WIDTH'(1);
            k       <= NW'(1);
            n_q     <= '0;
            exact_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zpend   <= 1'b0;
`ifdef INVERSE_FACTORIAL_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            v_q     <= v_d;
            prod    <= prod_d;
            k       <= k_d;
            n_q     <= n_d;
            exact_q <= exact_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zpend   <= zpend_d;
`ifdef INVERSE_FACTORIAL_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign n     = n_q;
    assign exact = exact_q;
`ifdef INVERSE_FACTORIAL_ERR_EN
    assign err   = err_q;
`endif

endmodule
